muldiv_unit: RTL

Parametrised multi-cycle execution unit for the RV32M/RV64M multiply-divide group, sitting beside the main ALU in the execute stage. It decodes op/funct7/funct3 itself, so no ALUControl encoding is involved. Operands are accepted over a valid/ready handshake, iterated one bit per cycle, and the result is held until the consumer accepts it. Division by zero and signed overflow are handled on a single-cycle fast path.

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide execution unit.
// Decodes op/funct7/funct3 itself and takes operands over a valid/ready
// handshake. It iterates one bit per cycle (shift-add multiply or
// restoring divide) on operand magnitudes, then applies the sign at the
// end. Divide-by-zero, signed overflow and illegal ops finish in one cycle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | XLEN iterations of shift-add / restoring divide
// DONE  | result held until out_ready

module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, dvsr;
    logic [2:0]        f3_q;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   result_q;
    logic              illegal_q;

    // request decode, operand magnitudes and fast-path detection
    logic              legal, is_div, sgn_a, sgn_b, na, nb;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res;

    // one iteration step of either algorithm, plus the signed final value
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_dif;
    logic              div_ge, last;
    logic [XLEN-1:0]   hi_step, lo_step, quo, rem, calc_res;
    logic [2*XLEN-1:0] prod, prod_s;

    // decode the incoming request and compute fast-path results
    always_comb begin
        legal    = (op == 7'b0110011) && (funct7 == 7'b0000001);
        is_div   = funct3[2];
        sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                   (funct3 == 3'b110);
        na       = sgn_a & src_a[XLEN-1];
        nb       = sgn_b & src_b[XLEN-1];
        a_mag    = na ? -src_a : src_a;
        b_mag    = nb ? -src_b : src_b;
        div_zero = (src_b == '0);
        div_ovf  = ~funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
        fast     = legal & is_div & (div_zero | div_ovf);
        if (div_zero)
            fast_res = funct3[1] ? src_a : '1;
        else
            fast_res = funct3[1] ? '0 : src_a;
    end

    // single iteration: hi/lo hold product halves or remainder/quotient
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
        div_sh  = {hi, lo[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, dvsr});
        div_dif = div_sh[XLEN-1:0] - dvsr;
        if (f3_q[2]) begin
            hi_step = div_ge ? div_dif : div_sh[XLEN-1:0];
            lo_step = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_step, lo_step};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_step : lo_step;
        rem    = neg_r ? -hi_step : hi_step;
        if (f3_q[2])
            calc_res = f3_q[1] ? rem : quo;
        else if (f3_q[1:0] == 2'b00)
            calc_res = prod_s[XLEN-1:0];
        else
            calc_res = prod_s[2*XLEN-1:XLEN];
        last = (cnt == CNT_W'(XLEN - 1));
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_nxt = (legal && !fast) ? CALC : DONE;
            end
            CALC: begin
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            dvsr      <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        f3_q      <= funct3;
                        neg_q     <= na ^ nb;
                        neg_r     <= na;
                        cnt       <= '0;
                        hi        <= '0;
                        lo        <= is_div ? a_mag : b_mag;
                        dvsr      <= is_div ? b_mag : a_mag;
                        illegal_q <= ~legal;
                        result_q  <= (legal && fast) ? fast_res : '0;
                    end
                end
                CALC: begin
                    hi  <= hi_step;
                    lo  <= lo_step;
                    cnt <= cnt + CNT_W'(1);
                    if (last)
                        result_q <= calc_res;
                end
                default: ;
            endcase
        end
    end

    assign result  = result_q;
    assign illegal = illegal_q;

endmodule
